// File: rtl/seg7_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_result_display
//  Description : Captures a 5-bit sign-magnitude result and a divide-by-zero
//                flag, then time-multiplexes them onto a three-digit
//                common-anode seven-segment display (sign, tens, units) or
//                shows "Err" while the error flag is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] result,
  input  logic       divbyzero,
  output logic [2:0] an,
  output logic [6:0] seg
);

  // Counter wide enough to hold REFRESH_DIV-1 (REFRESH_DIV >= 2).
  localparam int                 c_CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

  // Active-low segment patterns, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_MINUS = 7'b0111111;
  localparam logic [6:0] c_SEG_E     = 7'b0000110;
  localparam logic [6:0] c_SEG_R     = 7'b0101111;
  localparam logic [6:0] c_SEG_ONE   = 7'b1111001;

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [4:0]         r_val;
  logic               r_err;
  logic [2:0]         r_an;
  logic [6:0]         r_seg;

  logic [3:0]         w_mag;
  logic [3:0]         w_units;
  logic [6:0]         w_units_seg;
  logic [2:0]         w_an;
  logic [6:0]         w_seg;

  // Capture the result bus on the load strobe; a new load simply overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_err <= 1'b0;
    end else if (load) begin
      r_val <= result;
      r_err <= divbyzero;
    end
  end

  // Refresh counter and digit index; an out-of-range index recovers to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_idx == 2'd3) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_mag   = r_val[3:0];
  assign w_units = (w_mag >= 4'd10) ? (w_mag - 4'd10) : w_mag;

  // Decimal digit to segment pattern for the units position.
  always_comb begin
    w_units_seg = c_SEG_BLANK;
    case (w_units)
      4'd0:    w_units_seg = 7'b1000000;
      4'd1:    w_units_seg = 7'b1111001;
      4'd2:    w_units_seg = 7'b0100100;
      4'd3:    w_units_seg = 7'b0110000;
      4'd4:    w_units_seg = 7'b0011001;
      4'd5:    w_units_seg = 7'b0010010;
      4'd6:    w_units_seg = 7'b0000010;
      4'd7:    w_units_seg = 7'b1111000;
      4'd8:    w_units_seg = 7'b0000000;
      4'd9:    w_units_seg = 7'b0010000;
      default: w_units_seg = c_SEG_BLANK;
    endcase
  end

  // Select the anode and glyph for the digit currently being scanned.
  always_comb begin
    w_an  = 3'b111;
    w_seg = c_SEG_BLANK;
    case (r_idx)
      2'd0: begin
        w_an  = 3'b110;
        w_seg = r_err ? c_SEG_R : w_units_seg;
      end
      2'd1: begin
        w_an  = 3'b101;
        if (r_err)              w_seg = c_SEG_R;
        else if (w_mag >= 4'd10) w_seg = c_SEG_ONE;
        else                    w_seg = c_SEG_BLANK;
      end
      2'd2: begin
        w_an  = 3'b011;
        // Negative zero shows no sign.
        if (r_err)                          w_seg = c_SEG_E;
        else if (r_val[4] && w_mag != 4'd0) w_seg = c_SEG_MINUS;
        else                                w_seg = c_SEG_BLANK;
      end
      default: begin
        w_an  = 3'b111;
        w_seg = c_SEG_BLANK;
      end
    endcase
  end

  // Register anode and segments together so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 3'b111;
      r_seg <= c_SEG_BLANK;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_result_display
//  Description : Directed self-checking bench for seg7_result_display with a
//                short refresh period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_result_display;

  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] c_S0  = 7'b1000000;
  localparam logic [6:0] c_S1  = 7'b1111001;
  localparam logic [6:0] c_S2  = 7'b0100100;
  localparam logic [6:0] c_S3  = 7'b0110000;
  localparam logic [6:0] c_S7  = 7'b1111000;
  localparam logic [6:0] c_S9  = 7'b0010000;
  localparam logic [6:0] c_SBL = 7'b1111111;
  localparam logic [6:0] c_SMI = 7'b0111111;
  localparam logic [6:0] c_SE  = 7'b0000110;
  localparam logic [6:0] c_SR  = 7'b0101111;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] result;
  logic       divbyzero;
  logic [2:0] an;
  logic [6:0] seg;

  int n_cmp;
  int n_bad;

  seg7_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .result    (result),
    .divbyzero (divbyzero),
    .an        (an),
    .seg       (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Step until the given anode pattern is showing, bounded.
  task automatic wait_an(input string tag, input logic [2:0] target);
    for (int i = 0; i < 40 && an !== target; i++) tick();
    chk(tag, {4'b0, an}, {4'b0, target});
  endtask

  task automatic do_load(input logic [4:0] r, input logic dz);
    result    = r;
    divbyzero = dz;
    load      = 1'b1;
    tick();
    load      = 1'b0;
    tick();
  endtask

  task automatic chk_digits(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                            input logic [6:0] e0);
    wait_an({tag, "_an0"}, 3'b110);
    chk({tag, "_units"}, seg, e0);
    wait_an({tag, "_an1"}, 3'b101);
    chk({tag, "_tens"}, seg, e1);
    wait_an({tag, "_an2"}, 3'b011);
    chk({tag, "_sign"}, seg, e2);
  endtask

  logic [2:0] exp_an;
  logic [6:0] exp_seg;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    result    = 5'd0;
    divbyzero = 1'b0;

    // Reset state.
    #23;
    chk("rst_an", {4'b0, an}, 7'b0000111);
    chk("rst_seg", seg, c_SBL);

    // Release reset between edges, then watch 13 scan cycles.
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k < 4)       begin exp_an = 3'b110; exp_seg = c_S0;  end
      else if (k < 8)  begin exp_an = 3'b101; exp_seg = c_SBL; end
      else if (k < 12) begin exp_an = 3'b011; exp_seg = c_SBL; end
      else             begin exp_an = 3'b110; exp_seg = c_S0;  end
      chk($sformatf("scan_an_%0d", k), {4'b0, an}, {4'b0, exp_an});
      chk($sformatf("scan_seg_%0d", k), seg, exp_seg);
    end

    // +13
    do_load(5'b01101, 1'b0);
    chk_digits("pos13", c_SBL, c_S1, c_S3);

    // -7
    do_load(5'b10111, 1'b0);
    chk_digits("neg7", c_SMI, c_SBL, c_S7);

    // Negative zero
    do_load(5'b10000, 1'b0);
    chk_digits("negz", c_SBL, c_SBL, c_S0);

    // Divide-by-zero shows Err
    do_load(5'b11111, 1'b1);
    chk_digits("err", c_SE, c_SR, c_SR);

    // Clear error with a fresh load
    do_load(5'b00010, 1'b0);
    chk_digits("clr", c_SBL, c_SBL, c_S2);

    // Load +9 on the very edge the scan wraps back to the units digit.
    wait_an("align_a", 3'b101);
    wait_an("align_b", 3'b011);
    tick();
    tick();
    result    = 5'b01001;
    divbyzero = 1'b0;
    load      = 1'b1;
    tick();
    load      = 1'b0;
    chk("adv_pre_an", {4'b0, an}, 7'b0000011);
    tick();
    chk("adv_an", {4'b0, an}, 7'b0000110);
    chk("adv_seg", seg, c_S9);

    // Asynchronous reset mid-frame, with a load held during reset.
    tick();
    tick();
    #2;
    rst_n     = 1'b0;
    result    = 5'b01001;
    load      = 1'b1;
    #1;
    chk("arst_an", {4'b0, an}, 7'b0000111);
    chk("arst_seg", seg, c_SBL);
    tick();
    chk("arst_hold_an", {4'b0, an}, 7'b0000111);
    #2;
    load  = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_an", {4'b0, an}, 7'b0000110);
    chk("post_rst_seg", seg, c_S0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_result_display.md
# seg7_result_display

Downstream display stage for the arithmetic units' result bus. Captures a 5-bit sign-magnitude result (bit 4 = sign, bits 3:0 = magnitude) plus the divide-by-zero flag from the remainder/arithmetic block on a load strobe. Scans the captured value onto a three-digit, common-anode seven-segment display: sign, tens, units, or "Err" when the flag is set.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit stays enabled before the scan advances; legal range 2 to 2^20.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; captures result and divbyzero on this edge.
- result  input  5  bit 4 = sign (1 = negative), bits 3:0 = magnitude 0-15.
- divbyzero  input  1  error flag from the arithmetic stage.
- an  output  3  active-low digit enables: an[0] units, an[1] tens, an[2] sign/"E".
- seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.

## Operation
- Capture registers: val_q[4:0] and err_q.
  - On load = 1 they take result and divbyzero at the clock edge.
  - Otherwise they hold. A new load overwrites them at any time, with no handshake or backpressure.
- Scan counter cnt runs 0 to REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the digit index idx advances 0 -> 1 -> 2 -> 0. idx = 3 never occurs; if reached, it is forced to 0 on the next edge.
- Registered outputs are computed every cycle from idx, val_q and err_q:
  - an = one-hot-low of idx: idx 0 -> 3'b110, idx 1 -> 3'b101, idx 2 -> 3'b011.
  - Normal mode (err_q = 0), with m = val_q[3:0]:
    - idx 0: decimal units digit, m mod 10.
    - idx 1: "1" if m >= 10, else blank (leading-zero suppression).
    - idx 2: "-" if val_q[4] = 1 and m != 0, else blank. Negative zero displays as " 0".
  - Error mode (err_q = 1), regardless of val_q: idx 2 "E", idx 1 "r", idx 0 "r".
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - "-" = 0111111, blank = 1111111, "E" = 0000110, "r" = 0101111.
- Exactly one an bit is low in every cycle after the first post-reset edge.

## Timing
- Reset (rst_n = 0, asynchronous):
  - an = 3'b111, seg = 7'b1111111.
  - cnt = 0, idx = 0, val_q = 0, err_q = 0.
- First rising edge after rst_n deasserts: an = 3'b110 and seg = "0" (units digit of the reset value).
- Load latency:
  - Edge N captures the inputs.
  - From edge N+1, seg reflects the new value for the currently enabled digit.
  - The other digits update when the scan reaches them.
  - A load in the same cycle as a scan advance still has exactly this latency.
- Scan period: each digit is enabled for REFRESH_DIV consecutive cycles. A full frame is 3*REFRESH_DIV cycles.
- an and seg change on the same edge; there is no cycle where the new an is paired with the old digit's seg.
- Reset mid-scan or mid-load: all state returns immediately to reset values. A load asserted while rst_n = 0 is ignored.
- Clearing the error takes a load with divbyzero = 0.

## Test plan
- Reset and first digit, REFRESH_DIV = 4: hold rst_n low -> an = 111, seg = 1111111. Release -> after the first edge, an = 110 and seg = 1000000; an stays 110 for 4 cycles, then goes to 101.
- Scan order: after reset, run 12 cycles -> an sequence is 4×110, 4×101, 4×011, then back to 110.
- Positive two-digit value: load result = 5'b01101 (+13) -> units "3" = 0110000, tens "1" = 1111001, sign blank.
- Negative value and negative zero:
  - result = 5'b10111 (-7) -> units "7", tens blank, sign "-" = 0111111.
  - result = 5'b10000 -> sign blank.
- Divide-by-zero: load divbyzero = 1 with result = 5'b11111 -> digits 2/1/0 show 0000110 / 0101111 / 0101111. A later load with divbyzero = 0 and result = 5'b00010 -> units "2", tens blank, sign blank.
- Load and reset mid-scan:
  - Load +9 on the same edge the scan advances to idx 0 -> seg = 0010000 on the next edge.
  - Assert rst_n low mid-frame -> an = 111 and seg = 1111111 immediately, without waiting for a clock edge.
